// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// reset defaults and the width of the response timeout counter.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int          TIMEOUT_DEFAULT  = 255;
    localparam int          CNT_W            = 8;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one memory read per instruction at the
// current pc, waits (bounded) for the response, and hands the word to the
// decoder. Redirects from the execute unit override the sequential pc;
// a response already in flight when a redirect arrives is discarded.
//
// Handshakes: mem_req/mem_gnt transfer the request on a cycle where both are
// high; mem_rvalid is a one-cycle response strobe honoured only in WAIT;
// inst_valid/inst_ready transfer the instruction on a cycle where both are
// high, and inst/inst_pc do not change while inst_valid waits for inst_ready.
import fetch_pkg::*;

module inst_fetch #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    output logic         fault,
    output logic         busy,
    output fetch_state_t state_dbg
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    fetch_state_t     state, state_n;
    logic [31:0]      pc, pc_n;
    logic [31:0]      inst_n, inst_pc_n;
    logic             drop, drop_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            inst_pc <= '0;
            drop    <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            inst    <= inst_n;
            inst_pc <= inst_pc_n;
            drop    <= drop_n;
            cnt     <= cnt_n;
        end
    end

    // Next-state, pc selection, response capture and timeout counting.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        inst_n    = inst;
        inst_pc_n = inst_pc;
        drop_n    = drop;
        cnt_n     = cnt;
        case (state)
            ST_IDLE: begin
                if (redirect_valid) pc_n = redirect_pc;
                if (run) state_n = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) pc_n = redirect_pc;
                if (pc[1:0] != 2'b00) begin
                    // Misaligned pc is never presented to memory.
                    state_n = ST_FAULT;
                end else if (mem_gnt) begin
                    state_n = ST_WAIT;
                    cnt_n   = '0;
                    // The granted request targets the old pc; drop its data.
                    drop_n  = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_n   = redirect_pc;
                    drop_n = 1'b1;
                end
                if (mem_rvalid) begin
                    if (drop || redirect_valid) begin
                        state_n = ST_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        inst_n    = mem_rdata;
                        inst_pc_n = pc;
                        state_n   = ST_HOLD;
                    end
                end else if (cnt == TIMEOUT_C) begin
                    state_n = ST_FAULT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                // Redirect wins over the sequential increment.
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = run ? ST_REQ : ST_IDLE;
                end else if (inst_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = run ? ST_REQ : ST_IDLE;
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Moore outputs, forced quiet while reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        inst_valid = 1'b0;
        busy       = 1'b0;
        fault      = 1'b0;
        if (!rst) begin
            mem_req    = (state == ST_REQ) && (pc[1:0] == 2'b00);
            inst_valid = (state == ST_HOLD);
            busy       = (state == ST_REQ) || (state == ST_WAIT);
            fault      = (state == ST_FAULT);
        end
    end

    assign mem_addr  = pc;
    assign state_dbg = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with a handoff scoreboard.
import fetch_pkg::*;

module tb_inst_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         fault;
    logic         busy;
    fetch_state_t state_dbg;

    int checks   = 0;
    int passes   = 0;
    int handoffs = 0;
    int bad_req  = 0;

    // expected {inst_pc, inst} per handoff
    logic [63:0] exp_q[$];

    inst_fetch dut (
        .clk(clk), .rst(rst), .run(run),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .fault(fault), .busy(busy), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard: a handoff happens at the posedge after valid&ready seen here
    always @(negedge clk) begin
        if (!rst && mem_req && mem_addr[1:0] != 2'b00) bad_req++;
        if (!rst && inst_valid && inst_ready) begin
            logic [63:0] e;
            handoffs++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL handoff_unexpected: got pc=%h inst=%h, required no handoff", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc, inst} !== e)
                    $display("FAIL handoff: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc, inst, e[63:32], e[31:0]);
                else passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // reset, then run=1 and step into REQ at the reset pc
    task automatic start();
        do_reset();
        run = 1'b1;
        tick();
    endtask

    // from REQ: grant after gdly cycles, respond rdly cycles later; ends in HOLD
    task automatic fetch_one(input logic [31:0] pc_exp, input logic [31:0] data,
                             input int gdly, input int rdly);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== pc_exp)
            $display("FAIL fetch_req: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, pc_exp);
        else passes++;
        for (int i = 0; i < gdly; i++) tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < rdly; i++) tick();
        mem_rvalid = 1'b1; mem_rdata = data;
        exp_q.push_back({pc_exp, data});
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== data || inst_pc !== pc_exp)
            $display("FAIL fetch_hold: got valid=%b inst=%h pc=%h, required 1 %h %h", inst_valid, inst, inst_pc, data, pc_exp);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_req, inst_valid, busy} !== 3'b000)
            $display("FAIL reset_outputs: got req/valid/busy=%b, required 000", {mem_req, inst_valid, busy});
        else passes++;
        rst = 1'b0;
        checks++;
        if ({mem_req, inst_valid, busy, fault} !== 4'b0000 || mem_addr !== 32'h8000_0000 ||
            inst !== 32'h0 || inst_pc !== 32'h0)
            $display("FAIL reset_state: got req/valid/busy/fault=%b addr=%h inst=%h pc=%h, required 0000 80000000 0 0",
                     {mem_req, inst_valid, busy, fault}, mem_addr, inst, inst_pc);
        else passes++;
    endtask

    task automatic test_basic();
        start();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_wait: got req=%b busy=%b, required 0 1", mem_req, busy);
        else passes++;
        mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
        exp_q.push_back({32'h8000_0000, 32'h0010_0093});
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000 || busy !== 1'b0)
            $display("FAIL basic_latency: got valid=%b inst=%h pc=%h busy=%b, required 1 00100093 80000000 0",
                     inst_valid, inst, inst_pc, busy);
        else passes++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004)
            $display("FAIL basic_next: got req=%b addr=%h, required 1 80000004", mem_req, mem_addr);
        else passes++;
    endtask

    task automatic test_hold_stall();
        logic [31:0] d;
        int bad;
        d = $urandom;
        bad = 0;
        fetch_one(32'h8000_0004, d, 1, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (inst_valid !== 1'b1 || inst !== d || inst_pc !== 32'h8000_0004 || mem_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL hold_stable: got %0d unstable cycles, required 0", bad);
        else passes++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick(); tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0008)
            $display("FAIL hold_advance: got req=%b addr=%h, required 1 80000008", mem_req, mem_addr);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        p = 32'h8000_0008;
        for (int i = 0; i < 4; i++) begin
            fetch_one(p, $urandom, 0, 0);
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
            p = p + 32'd4;
        end
        for (int i = 0; i < 4; i++) begin
            fetch_one(p, $urandom, $urandom_range(0, 3), $urandom_range(0, 5));
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
            p = p + 32'd4;
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== p)
            $display("FAIL b2b_pc: got req=%b addr=%h, required 1 %h", mem_req, mem_addr, p);
        else passes++;
    endtask

    task automatic test_redirect_fetch();
        logic [31:0] d;
        start();
        // redirect while in WAIT
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0100)
            $display("FAIL redir_wait_drop: got valid=%b req=%b addr=%h, required 0 1 80000100", inst_valid, mem_req, mem_addr);
        else passes++;
        d = $urandom;
        fetch_one(32'h8000_0100, d, 0, 1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        // redirect coincident with grant
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; mem_gnt = 1'b1;
        tick();
        redirect_valid = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0200)
            $display("FAIL redir_gnt_drop: got valid=%b req=%b addr=%h, required 0 1 80000200", inst_valid, mem_req, mem_addr);
        else passes++;
        // redirect in REQ without grant, plus a stray response outside WAIT
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; mem_rvalid = 1'b1;
        tick();
        redirect_valid = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0300)
            $display("FAIL redir_req: got valid=%b req=%b addr=%h, required 0 1 80000300", inst_valid, mem_req, mem_addr);
        else passes++;
    endtask

    task automatic test_redirect_hold();
        int h0;
        fetch_one(32'h8000_0300, $urandom, 0, 0);
        h0 = handoffs;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0400; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        checks++;
        if (handoffs - h0 != 1 || inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0400)
            $display("FAIL redir_hold_ready: got handoffs=%0d valid=%b addr=%h, required 1 0 80000400",
                     handoffs - h0, inst_valid, mem_addr);
        else passes++;
        // redirect in HOLD without ready: instruction is withdrawn
        fetch_one(32'h8000_0400, $urandom, 0, 0);
        void'(exp_q.pop_back());
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0500)
            $display("FAIL redir_hold: got valid=%b req=%b addr=%h, required 0 1 80000500", inst_valid, mem_req, mem_addr);
        else passes++;
    endtask

    task automatic test_run_low();
        start();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        run = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        exp_q.push_back({32'h8000_0000, 32'hCAFE_0001});
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1) $display("FAIL run_low_hold: got valid=%b, required 1", inst_valid);
        else passes++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h8000_0004)
            $display("FAIL run_low_idle: got req=%b busy=%b addr=%h, required 0 0 80000004", mem_req, busy, mem_addr);
        else passes++;
    endtask

    task automatic test_misalign();
        int bad;
        start();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h8000_0102)
            $display("FAIL misalign_req: got req=%b addr=%h, required 0 80000102", mem_req, mem_addr);
        else passes++;
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            mem_gnt = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            tick();
            if (fault !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) bad++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL misalign_sticky: got %0d bad cycles, required 0", bad);
        else passes++;
        do_reset();
        checks++;
        if (fault !== 1'b0) $display("FAIL fault_clear: got fault=%b, required 0", fault);
        else passes++;
    endtask

    task automatic test_timeout();
        int n;
        start();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n = 0;
        while (fault !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 256) $display("FAIL timeout_cycles: got %0d, required 256", n);
        else passes++;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (fault !== 1'b1 || inst_valid !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL timeout_late: got fault=%b valid=%b req=%b, required 1 0 0", fault, inst_valid, mem_req);
        else passes++;
    endtask

    task automatic test_reset_mid();
        start();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || inst !== 32'h0)
            $display("FAIL reset_mid: got valid=%b busy=%b req=%b inst=%h, required 0 0 0 0", inst_valid, busy, mem_req, inst);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_back_to_back();
        test_redirect_fetch();
        test_redirect_hold();
        test_run_low();
        test_misalign();
        test_timeout();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
        else passes++;
        checks++;
        if (bad_req != 0) $display("FAIL misaligned_req: got %0d requests, required 0", bad_req);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
